bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble), one bit per clock. Accepts a WIDTH-bit unsigned value on a start strobe, iterates WIDTH shift steps with a per-digit add-3-if-≥5 correction, and presents DIGITS packed BCD digits with a one-cycle done pulse. It sits between the binary datapath and the BCD display/decoder stage. It instantiates one add-3-if-≥5 cell per BCD digit for the correction step.

---
 rtl/bin_to_bcd_seq.sv | 108 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock, WIDTH-cycle latency.
// Optional `BIN2BCD_BLANK_EN adds a registered leading-zero blank mask per digit.

module bin_to_bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  // Inputs never exceed 9, so the sum fits in 4 bits.
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state;
  logic [SW-1:0]       scratch;
  logic [SW-1:0]       corrected;
  logic [WIDTH-1:0]    bin_reg;
  logic [CW-1:0]       cnt;
  logic [SW+WIDTH-1:0] shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bin_to_bcd_add3 u_add3 (
      .din  (scratch[4*g +: 4]),
      .dout (corrected[4*g +: 4])
    );
  end

  // Bits leaving the top digit are always zero given 10^DIGITS > 2^WIDTH-1.
  assign shifted = {corrected, bin_reg} << 1;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;
  logic              zero_above;

  always_comb begin
    blank_nxt  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above & (shifted[WIDTH + 4*i +: 4] == 4'd0);
      blank_nxt[i] = zero_above;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      scratch <= '0;
      bin_reg <= '0;
      cnt     <= '0;
`ifdef BIN2BCD_BLANK_EN
      blank   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_reg <= bin_in;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted[SW+WIDTH-1:WIDTH];
          bin_reg <= shifted[WIDTH-1:0];
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_out <= shifted[SW+WIDTH-1:WIDTH];
`ifdef BIN2BCD_BLANK_EN
            blank   <= blank_nxt;
`endif
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed table, hand sequences and exhaustive sweeps at 8/3 and 4/2.
// Blank mask is checked when BIN2BCD_BLANK_EN is defined.

module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start4;
  logic [7:0]  bin8;
  logic [3:0]  bin4;
  logic        busy8, done8, busy4, done4;
  logic [11:0] bcd8;
  logic [7:0]  bcd4;
`ifdef BIN2BCD_BLANK_EN
  logic [2:0]  blank8;
  logic [1:0]  blank4;
`endif

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin_in(bin8),
    .busy(busy8), .done(done8), .bcd_out(bcd8)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank8)
`endif
  );

  bin_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bin_in(bin4),
    .busy(busy4), .done(done4), .bcd_out(bcd4)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank4)
`endif
  );

  typedef struct {
    logic [11:0] bcd;
    logic [2:0]  blank;
  } exp_t;

  typedef struct {
    int          bin;
    logic [11:0] bcd;
    logic [2:0]  blank;
  } vec_t;

  exp_t q8[$];
  exp_t q4[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [11:0] ref_bcd(int v, int nd);
    logic [11:0] r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] ref_blank(int v, int nd);
    logic [2:0] r = '0;
    int p = 1;
    for (int i = 1; i < nd; i++) begin
      p = p * 10;
      r[i] = (v < p);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and score any result either DUT just produced.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (done8) begin
      if (q8.size() == 0) chk("done8_unexpected", 32'(done8), 32'd0);
      else begin
        e = q8.pop_front();
        chk("bcd8", 32'(bcd8), 32'(e.bcd));
`ifdef BIN2BCD_BLANK_EN
        chk("blank8", 32'(blank8), 32'(e.blank));
`endif
      end
    end
    if (done4) begin
      if (q4.size() == 0) chk("done4_unexpected", 32'(done4), 32'd0);
      else begin
        e = q4.pop_front();
        chk("bcd4", 32'(bcd4), 32'(e.bcd[7:0]));
`ifdef BIN2BCD_BLANK_EN
        chk("blank4", 32'(blank4), 32'(e.blank[1:0]));
`endif
      end
    end
  endtask

  task automatic run8(input int v, input logic [11:0] b, input logic [2:0] bl);
    bin8   = 8'(v);
    start8 = 1'b1;
    q8.push_back('{bcd: b, blank: bl});
    step();
    start8 = 1'b0;
    chk("busy8_after_start", 32'(busy8), 32'd1);
    repeat (7) step();
    chk("busy8_before_done", 32'({busy8, done8}), 32'b10);
    step();
    chk("done8_at_latency", 32'({busy8, done8}), 32'b01);
    step();
    chk("done8_single_pulse", 32'(done8), 32'd0);
  endtask

  task automatic run4(input int v);
    bin4   = 4'(v);
    start4 = 1'b1;
    q4.push_back('{bcd: ref_bcd(v, 2), blank: ref_blank(v, 2)});
    step();
    start4 = 1'b0;
    repeat (3) step();
    step();
    chk("done4_at_latency", 32'({busy4, done4}), 32'b01);
    step();
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{bin: 255, bcd: 12'h255, blank: 3'b000};
    tbl[1] = '{bin: 0,   bcd: 12'h000, blank: 3'b110};
    tbl[2] = '{bin: 99,  bcd: 12'h099, blank: 3'b100};
    tbl[3] = '{bin: 128, bcd: 12'h128, blank: 3'b000};
    tbl[4] = '{bin: 5,   bcd: 12'h005, blank: 3'b110};
    tbl[5] = '{bin: 200, bcd: 12'h200, blank: 3'b000};
    tbl[6] = '{bin: 10,  bcd: 12'h010, blank: 3'b100};

    rst = 1'b1; start8 = 1'b0; start4 = 1'b0; bin8 = '0; bin4 = '0;
    step();
    start8 = 1'b1;
    bin8   = 8'd77;
    step();
    chk("reset_outputs8", 32'({busy8, done8, bcd8}), 32'd0);
    chk("reset_outputs4", 32'({busy4, done4, bcd4}), 32'd0);
`ifdef BIN2BCD_BLANK_EN
    chk("reset_blank8", 32'(blank8), 32'd0);
`endif
    start8 = 1'b0;
    rst    = 1'b0;
    step();
    chk("idle_after_reset", 32'(busy8), 32'd0);

    for (int i = 0; i < 7; i++) run8(tbl[i].bin, tbl[i].bcd, tbl[i].blank);

    // Second start mid-conversion is ignored: one done, result 099.
    bin8 = 8'd99; start8 = 1'b1;
    q8.push_back('{bcd: 12'h099, blank: 3'b100});
    step();
    start8 = 1'b0;
    repeat (2) step();
    bin8 = 8'd7; start8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (4) step();
    step();
    chk("ignored_start_done", 32'(done8), 32'd1);
    repeat (4) step();
    chk("ignored_start_queue", 32'(q8.size()), 32'd0);

    // Reset mid-conversion aborts and clears the held result.
    bin8 = 8'd200; start8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("abort_outputs", 32'({busy8, done8, bcd8}), 32'd0);
`ifdef BIN2BCD_BLANK_EN
    chk("abort_blank", 32'(blank8), 32'd0);
`endif
    rst = 1'b0;
    run8(128, 12'h128, 3'b000);

    // Start held high: back-to-back conversions, bin_in changes after acceptance.
    bin8 = 8'd5; start8 = 1'b1;
    q8.push_back('{bcd: 12'h005, blank: 3'b110});
    q8.push_back('{bcd: 12'h009, blank: 3'b110});
    step();
    bin8 = 8'd9;
    repeat (7) step();
    step();
    chk("held_first_done", 32'(done8), 32'd1);
    step();
    chk("held_second_busy", 32'({busy8, done8}), 32'b10);
    start8 = 1'b0;
    repeat (7) step();
    step();
    chk("held_second_done", 32'(done8), 32'd1);
    step();
    chk("held_queue", 32'(q8.size()), 32'd0);

    for (int v = 0; v < 256; v++) run8(v, ref_bcd(v, 3), ref_blank(v, 3));
    for (int v = 0; v < 16; v++) run4(v);

    repeat (3) step();
    chk("final_queue8", 32'(q8.size()), 32'd0);
    chk("final_queue4", 32'(q4.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
